// File: rtl/siso_pkg.sv
// siso_pkg: shared width limits and parameter check for the serial delay line
package siso_pkg;
  localparam int SISO_DEFAULT_WIDTH = 4;
  localparam int SISO_MAX_WIDTH = 64;
  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= SISO_MAX_WIDTH);
  endfunction
endpackage

// File: rtl/siso_stage.sv
// siso_stage: one D flop with asynchronous active-low clear
module siso_stage
  import siso_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  // capture d every edge; clear immediately while rst is low
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/siso_shift_reg.sv
// siso_shift_reg: WIDTH-stage serial delay line; SISO_TAP_EN adds parallel tap output
module siso_shift_reg
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
`ifdef SISO_TAP_EN
  ,
  output logic [WIDTH-1:0] tap
`endif
);
  logic [WIDTH:0] chain;
  if (!width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "siso_shift_reg: WIDTH must be in 1..%0d", SISO_MAX_WIDTH);
  end
  assign chain[0] = in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    siso_stage u_stage (
      .clk(clk),
      .rst(rst),
      .d  (chain[i]),
      .q  (chain[i+1])
    );
  end
  assign out = chain[WIDTH];
`ifdef SISO_TAP_EN
  assign tap = chain[WIDTH:1];
`endif
endmodule

// File: tb/tb_siso_shift_reg.sv
// tb_siso_shift_reg: directed and random checks of the delay line against a history model
module tb_siso_shift_reg;
  localparam int W = 4;
  logic clk, rst, in, out, out1;
`ifdef SISO_TAP_EN
  logic [W-1:0] tap;
  logic [0:0] tap1;
`endif
  int total = 0;
  int bad = 0;
  logic hist[$];
  int ones;

  siso_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out)
`ifdef SISO_TAP_EN
    , .tap(tap)
`endif
  );

  siso_shift_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in), .out(out1)
`ifdef SISO_TAP_EN
    , .tap(tap1)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // bit captured w edges ago, or 0 if fewer than w edges since reset
  function automatic logic model_out(input int w);
    int n = hist.size();
    return (n >= w) ? hist[n-w] : 1'b0;
  endfunction

  function automatic logic [W-1:0] model_tap();
    logic [W-1:0] v = '0;
    int n = hist.size();
    for (int i = 0; i < W; i++) if (n - 1 - i >= 0) v[i] = hist[n-1-i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_out"}, 64'(out), 64'(model_out(W)));
    chk({tag, "_out1"}, 64'(out1), 64'(model_out(1)));
`ifdef SISO_TAP_EN
    chk({tag, "_tap"}, 64'(tap), 64'(model_tap()));
`endif
  endtask

  task automatic step(input logic b, input string tag);
    @(negedge clk);
    rst = 1'b1;
    in = b;
    @(posedge clk);
    hist.push_back(b);
    #1 chk_all(tag);
  endtask

  logic pat [14] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    rst = 1'b0;
    in = 1'b1;
    #1 chk("rst_t1", 64'(out), 0);
`ifdef SISO_TAP_EN
    chk("rst_tap_t1", 64'(tap), 0);
`endif
    @(posedge clk);
    #1 chk("rst_edge", 64'(out), 0);
    chk("rst_edge1", 64'(out1), 0);
`ifdef SISO_TAP_EN
    chk("rst_tap_edge", 64'(tap), 0);
`endif
    for (int k = 0; k < 14; k++) begin
      step(pat[k], "pattern");
      if (k == 4) chk("latency_pre", 64'(out), 0);
      if (k == 5) chk("latency_t65", 64'(out), 1);
    end
    for (int k = 0; k < W + 1; k++) step(1'b1, "fill");
    chk("pre_async", 64'(out), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_out", 64'(out), 0);
    chk("async_out1", 64'(out1), 0);
`ifdef SISO_TAP_EN
    chk("async_tap", 64'(tap), 0);
`endif
    hist.delete();
    @(posedge clk);
    #1 chk("hold_rst", 64'(out), 0);
    ones = 0;
    step(1'b1, "walk");
    ones += int'(out);
    for (int k = 0; k < W + 2; k++) begin
      step(1'b0, "walk");
      ones += int'(out);
    end
    chk("walk_pulse_len", 64'(ones), 1);
    for (int k = 0; k < 200; k++) begin
      if (k == 100) begin
        @(negedge clk);
        #3 rst = 1'b0;
        #1 chk("mid_rst", 64'(out), 0);
        hist.delete();
      end
      step(1'($urandom_range(0, 1)), "random");
    end
    for (int k = 0; k < 8; k++) step(1'(k % 2), "toggle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
